// File: rtl/bus_pkg.sv
// Shared constants for the serial-bus master port: frame/data widths, slave ids,
// FSM state codes and the address-frame builder.
package bus_pkg;

   localparam int ADDR_FRAME_W = 15;
   localparam int DATA_W       = 8;
   localparam int SLAVE_ID_W   = 2;
   localparam int MEM_ADDR_W   = 12;
   localparam int M_ADDR_W     = SLAVE_ID_W + MEM_ADDR_W;
   localparam int CNT_W        = 4;

   localparam logic [SLAVE_ID_W-1:0] SLAVE_ID_MEM0 = 2'd0;
   localparam logic [SLAVE_ID_W-1:0] SLAVE_ID_MEM1 = 2'd1;
   localparam logic [SLAVE_ID_W-1:0] SLAVE_ID_MEM2 = 2'd2;
   localparam logic [SLAVE_ID_W-1:0] SLAVE_ID_MEM3 = 2'd3;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_REQ    = 4'd1;
   localparam logic [3:0] ST_ADDR   = 4'd2;
   localparam logic [3:0] ST_WACK_A = 4'd3;
   localparam logic [3:0] ST_WDATA  = 4'd4;
   localparam logic [3:0] ST_WACK_D = 4'd5;
   localparam logic [3:0] ST_RDATA  = 4'd6;
   localparam logic [3:0] ST_DONE   = 4'd7;
   localparam logic [3:0] ST_ABORT  = 4'd8;

   // Frame bit 0 is the start bit; slave id and memory address follow LSB-first.
   function automatic logic [ADDR_FRAME_W-1:0] addr_frame(input logic [M_ADDR_W-1:0] addr);
      return {addr, 1'b1};
   endfunction

endpackage

// File: rtl/master_port_counter.sv
// Saturating up-counter with synchronous clear; used as the serial bit counter.
module counter #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments only.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/master_port.sv
// Serial-bus master port: latches one request, wins the bus, shifts the address frame
// and data byte, returns status. Optional ACK timeout under `MASTER_TIMEOUT_EN.
module master_port
   import bus_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                M_REQ,
   input  logic                M_RW,
   input  logic [M_ADDR_W-1:0] M_ADDR,
   input  logic [DATA_W-1:0]   M_WDATA,
   output logic                M_READY,
   output logic [DATA_W-1:0]   M_RDATA,
   output logic                M_DONE,
   output logic                M_ERR,
   output logic                B_REQ,
   input  logic                B_GRANT,
   output logic                B_VALID,
   output logic                B_RW,
   output logic                B_BUS_OUT,
   input  logic                B_BUS_IN,
   input  logic                B_ACK
);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_FRAME_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic [3:0]          state_d,  state_q;
   logic                rw_d,     rw_q;
   logic [M_ADDR_W-1:0] addr_d,   addr_q;
   logic [DATA_W-1:0]   wdata_d,  wdata_q;
   logic [DATA_W-1:0]   shift_d,  shift_q;
   logic [DATA_W-1:0]   rdata_d,  rdata_q;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_clr;
   logic                cnt_en;
   logic                bus_phase;
   logic                ack_timeout;
   logic [ADDR_FRAME_W-1:0] frame;

   counter #(.WIDTH(CNT_W)) u_bit_cnt (
      .CLK (CLK),
      .RSTN(RSTN),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt)
   );

   assign bus_phase = (state_q == ST_ADDR)  || (state_q == ST_WACK_A) || (state_q == ST_WDATA) ||
                      (state_q == ST_WACK_D) || (state_q == ST_RDATA);
   assign frame     = addr_frame(addr_q);

   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      shift_d = shift_q;
      rdata_d = rdata_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         ST_IDLE: if (M_REQ) begin
            rw_d    = M_RW;
            addr_d  = M_ADDR;
            wdata_d = M_WDATA;
            cnt_clr = 1'b1;
            state_d = ST_REQ;
         end
         ST_REQ: if (B_GRANT) state_d = ST_ADDR;
         ST_ADDR: begin
            cnt_en = 1'b1;
            if (cnt == ADDR_LAST) begin
               cnt_clr = 1'b1;
               state_d = ST_WACK_A;
            end
         end
         ST_WACK_A: begin
            cnt_clr = 1'b1;
            if (B_ACK)            state_d = rw_q ? ST_WDATA : ST_RDATA;
            else if (ack_timeout) state_d = ST_ABORT;
         end
         ST_WDATA: begin
            cnt_en = 1'b1;
            if (cnt == DATA_LAST) begin
               cnt_clr = 1'b1;
               state_d = ST_WACK_D;
            end
         end
         ST_WACK_D: begin
            if (B_ACK)            state_d = ST_DONE;
            else if (ack_timeout) state_d = ST_ABORT;
         end
         ST_RDATA: begin
            cnt_en            = 1'b1;
            shift_d[cnt[2:0]] = B_BUS_IN;
            if (cnt == DATA_LAST) begin
               rdata_d = {B_BUS_IN, shift_q[DATA_W-2:0]};
               cnt_clr = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Losing the grant mid-frame wins over any other transition and keeps old read data.
      if (bus_phase && !B_GRANT) begin
         rdata_d = rdata_q;
         cnt_clr = 1'b1;
         state_d = ST_ABORT;
      end
   end

`ifdef MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TO_W-1:0] wait_d, wait_q;
   logic            in_wait;

   assign in_wait     = (state_q == ST_WACK_A) || (state_q == ST_WACK_D);
   assign ack_timeout = in_wait && (wait_q == TO_W'(ACK_TIMEOUT - 1));

   always_comb begin
      wait_d = '0;
      if (in_wait && (state_d == state_q)) wait_d = wait_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) wait_q <= '0;
      else       wait_q <= wait_d;
   end
`else
   // Without the timeout the FSM waits for B_ACK forever; ACK_TIMEOUT has no effect.
   assign ack_timeout = (ACK_TIMEOUT < 0);
`endif

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_IDLE;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         shift_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         shift_q <= shift_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      B_BUS_OUT = 1'b0;
      if (state_q == ST_ADDR)  B_BUS_OUT = frame[cnt];
      if (state_q == ST_WDATA) B_BUS_OUT = wdata_q[cnt[2:0]];
   end

   assign M_READY = (state_q == ST_IDLE);
   assign M_DONE  = (state_q == ST_DONE);
   assign M_ERR   = (state_q == ST_ABORT);
   assign M_RDATA = rdata_q;
   assign B_REQ   = (state_q == ST_REQ) || bus_phase;
   assign B_VALID = bus_phase;
   assign B_RW    = rw_q & bus_phase;

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: the driver acts as requester, arbiter and slave;
// a monitor pops expected completions whenever M_DONE or M_ERR fires.
module tb_master_port;

   localparam int ACK_TIMEOUT = 15;

   typedef struct {
      bit         err;
      logic [7:0] rdata;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        M_REQ = 1'b0;
   logic        M_RW = 1'b0;
   logic [13:0] M_ADDR = '0;
   logic [7:0]  M_WDATA = '0;
   logic        M_READY;
   logic [7:0]  M_RDATA;
   logic        M_DONE;
   logic        M_ERR;
   logic        B_REQ;
   logic        B_GRANT = 1'b0;
   logic        B_VALID;
   logic        B_RW;
   logic        B_BUS_OUT;
   logic        B_BUS_IN = 1'b0;
   logic        B_ACK = 1'b0;

   int          tests = 0;
   int          fails = 0;
   exp_t        exp_q[$];
   logic [7:0]  mem [int];
   logic [7:0]  last_rdata = '0;

   master_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .M_REQ    (M_REQ),
      .M_RW     (M_RW),
      .M_ADDR   (M_ADDR),
      .M_WDATA  (M_WDATA),
      .M_READY  (M_READY),
      .M_RDATA  (M_RDATA),
      .M_DONE   (M_DONE),
      .M_ERR    (M_ERR),
      .B_REQ    (B_REQ),
      .B_GRANT  (B_GRANT),
      .B_VALID  (B_VALID),
      .B_RW     (B_RW),
      .B_BUS_OUT(B_BUS_OUT),
      .B_BUS_IN (B_BUS_IN),
      .B_ACK    (B_ACK)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [7:0] mem_rd(input logic [13:0] a);
      if (!mem.exists(int'(a))) mem[int'(a)] = 8'($urandom);
      return mem[int'(a)];
   endfunction

   // Completion monitor: every DONE/ERR pulse must match the oldest outstanding request.
   always @(negedge CLK) begin
      if (RSTN && (M_DONE || M_ERR)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, M_DONE, M_ERR}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("event_kind_err", M_ERR, e.err);
            check("event_single", M_DONE & M_ERR, 0);
            check("event_rdata", M_RDATA, e.rdata);
         end
      end
   end

   task automatic run_txn(input bit rw, input logic [13:0] addr, input logic [7:0] wd,
                          input int gdly, input int adly, input int ddly,
                          input int abort_bit, input int rst_bit, input bit noack);
      int         frame;
      logic [7:0] rd;
      bit         to_abort;
      exp_t       e;
      to_abort = (abort_bit >= 0);
`ifdef MASTER_TIMEOUT_EN
      if (noack) to_abort = 1'b1;
`endif
      rd    = rw ? 8'h00 : mem_rd(addr);
      frame = (int'(addr) << 1) | 1;
      for (int w = 0; w < 50 && M_READY !== 1'b1; w++) step();
      check("ready_idle", M_READY, 1);
      M_REQ = 1'b1; M_RW = rw; M_ADDR = addr; M_WDATA = wd;
      if (rst_bit < 0) begin
         e.err   = to_abort;
         e.rdata = (!to_abort && !rw) ? rd : last_rdata;
         exp_q.push_back(e);
         last_rdata = e.rdata;
      end
      step();
      M_REQ = 1'b0; M_RW = 1'($urandom); M_ADDR = 14'($urandom); M_WDATA = 8'($urandom);
      check("req_ready_low", M_READY, 0);
      for (int g = 0; g < gdly; g++) begin
         check("grant_wait_breq", B_REQ, 1);
         check("grant_wait_bus", {B_VALID, B_BUS_OUT}, 0);
         step();
      end
      B_GRANT = 1'b1;
      step();
      for (int i = 0; i < 15; i++) begin
         check("addr_valid", B_VALID, 1);
         check("addr_rw", B_RW, rw);
         check("addr_bit", B_BUS_OUT, (frame >> i) & 1);
         B_ACK = 1'($urandom_range(0, 1));
         if (i == abort_bit) B_GRANT = 1'b0;
         step();
         if (i == abort_bit) begin
            B_ACK = 1'b0;
            check("abort_bus_idle", {B_REQ, B_VALID, B_BUS_OUT, B_RW}, 0);
            step();
            check("abort_ready", M_READY, 1);
            check("abort_drained", exp_q.size(), 0);
            return;
         end
      end
      B_ACK = 1'b0;
      if (noack) begin
`ifdef MASTER_TIMEOUT_EN
         for (int c = 0; c < ACK_TIMEOUT; c++) begin
            check("timeout_wait", {B_VALID, M_ERR}, 2'b10);
            step();
         end
         check("timeout_err", M_ERR, 1);
         B_GRANT = 1'b0;
         step();
         check("timeout_ready", M_READY, 1);
         check("timeout_drained", exp_q.size(), 0);
         return;
`else
         for (int c = 0; c < 100; c++) begin
            check("no_timeout_wait", {B_VALID, M_ERR, B_BUS_OUT}, 3'b100);
            step();
         end
`endif
      end else begin
         for (int c = 0; c < adly; c++) begin
            check("wack_a", {B_VALID, B_BUS_OUT}, 2'b10);
            step();
         end
      end
      B_ACK = 1'b1;
      step();
      B_ACK = 1'b0;
      if (rw) begin
         for (int i = 0; i < 8; i++) begin
            check("wdata_valid", B_VALID, 1);
            check("wdata_bit", B_BUS_OUT, (wd >> i) & 1);
            if (i == rst_bit) begin
               RSTN = 1'b0;
               #1;
               check("rst_outputs", {M_READY, M_DONE, M_ERR, B_REQ, B_VALID, B_RW, B_BUS_OUT}, 7'b1000000);
               check("rst_rdata", M_RDATA, 0);
               last_rdata = 8'h00;
               B_GRANT = 1'b0;
               step();
               step();
               RSTN = 1'b1;
               step();
               return;
            end
            step();
         end
         for (int c = 0; c < ddly; c++) begin
            check("wack_d", {B_VALID, B_REQ}, 2'b11);
            step();
         end
         B_ACK = 1'b1;
         step();
         B_ACK = 1'b0;
         mem[int'(addr)] = wd;
      end else begin
         for (int i = 0; i < 8; i++) begin
            check("rdata_valid", B_VALID, 1);
            B_BUS_IN = rd[i];
            step();
         end
         B_BUS_IN = 1'b0;
      end
      B_GRANT = 1'b0;
      check("done_bus_idle", {B_REQ, B_VALID, B_BUS_OUT, B_RW}, 0);
      step();
      check("done_ready", M_READY, 1);
      check("done_drained", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      check("reset_outputs", {M_READY, M_DONE, M_ERR, B_REQ, B_VALID, B_RW, B_BUS_OUT}, 7'b1000000);
      check("reset_rdata", M_RDATA, 0);
      step();
      RSTN = 1'b1;
      step();

      // Write id=2 addr 0A5 data 3C; frame 1,1,0,1,0,0,1,0,1,0,0,0,0,0,1.
      run_txn(1'b1, {2'd2, 12'h0A5}, 8'h3C, 0, 2, 1, -1, -1, 1'b0);
      // Read addr FFF with the slave returning AD.
      mem[int'({2'd1, 12'hFFF})] = 8'hAD;
      run_txn(1'b0, {2'd1, 12'hFFF}, 8'h00, 1, 0, 0, -1, -1, 1'b0);
      check("read_ad_held", M_RDATA, 8'hAD);
      // Long grant wait.
      run_txn(1'b1, {2'd0, 12'h123}, 8'h5A, 20, 0, 0, -1, -1, 1'b0);
      // Grant lost at address bit 7 keeps read data.
      run_txn(1'b0, {2'd3, 12'h456}, 8'h00, 2, 0, 0, 7, -1, 1'b0);
      check("abort_rdata_kept", M_RDATA, 8'hAD);
      // Reset mid write data, then a normal write.
      run_txn(1'b1, {2'd2, 12'h777}, 8'hC3, 0, 1, 0, -1, 3, 1'b0);
      run_txn(1'b1, {2'd2, 12'h778}, 8'h96, 0, 1, 2, -1, -1, 1'b0);
      // Missing ACK after the address frame.
      run_txn(1'b1, {2'd1, 12'h010}, 8'h11, 0, 0, 0, -1, -1, 1'b1);
      // Randomized traffic, reads often hitting earlier writes.
      for (int n = 0; n < 40; n++) begin
         logic [13:0] a;
         a = (n % 3 == 0 && mem.num() > 0) ? {2'd2, 12'h0A5} : 14'($urandom);
         run_txn(1'($urandom), a, 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 4),
                 $urandom_range(0, 4), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : -1,
                 -1, 1'b0);
      end
      step();
      step();
      check("final_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
